axi2mem_tcdm_port_arb: RTL and testbench

//  Shares one TCDM initiator port between NUM_REQ axi2mem TCDM interface channels (rd/wr lanes).

---
 rtl/axi2mem_tcdm_arb_pkg.sv | 34 +++
 rtl/axi2mem_tcdm_arb_outst_fifo.sv | 59 +++++
 rtl/axi2mem_tcdm_port_arb.sv | 215 +++++++++++++++++++++
 tb/tb_axi2mem_tcdm_port_arb.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_tcdm_arb_pkg.sv
// Shared types and width helpers for the axi2mem TCDM port arbiter.
// Widths below describe the default configuration; the top derives its own from its parameters.
package axi2mem_tcdm_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_OUTST_DEF = 4;

  localparam int BE_W  = DATA_W_DEF / 8;
  localparam int SEL_W = $clog2(NUM_REQ_DEF);
  localparam int CNT_W = $clog2(MAX_OUTST_DEF) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] add;
    logic                  we;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W-1:0]       be;
  } tcdm_req_t;

  function automatic int sel_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int cnt_width(input int max_outst);
    return $clog2(max_outst) + 1;
  endfunction

endpackage

// File: rtl/axi2mem_tcdm_arb_outst_fifo.sv
// In-order FIFO of channel indices for granted TCDM transactions awaiting r_valid.
// Accepts push and pop in the same cycle even when full.
module axi2mem_tcdm_arb_outst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_W + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    head_o,
  output logic [CNT_BITS-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi2mem_tcdm_port_arb.sv
// Round-robin arbiter sharing one TCDM port between NUM_REQ axi2mem channels, with in-order response routing.
// Optional perf counters are enabled by defining AXI2MEM_TCDM_ARB_PERF_EN.
module axi2mem_tcdm_port_arb
  import axi2mem_tcdm_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   add_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] be_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ*DATA_W-1:0]   r_rdata_o,
  output logic [NUM_REQ-1:0]          r_valid_o,
  output logic                        tcdm_req_o,
  output logic [ADDR_W-1:0]           tcdm_add_o,
  output logic                        tcdm_we_o,
  output logic [DATA_W-1:0]           tcdm_wdata_o,
  output logic [DATA_W/8-1:0]         tcdm_be_o,
  input  logic                        tcdm_gnt_i,
  input  logic [DATA_W-1:0]           tcdm_r_rdata_i,
  input  logic                        tcdm_r_valid_i,
  output logic                        err_o,
  input  logic                        perf_clr_i,
  output logic [NUM_REQ*32-1:0]       perf_gnt_cnt_o,
  output logic [31:0]                 perf_stall_cnt_o
);

  localparam int BE_BITS  = DATA_W / 8;
  localparam int SEL_BITS = sel_width(NUM_REQ);
  localparam int CNT_BITS = cnt_width(MAX_OUTST);
  localparam int SCAN_W   = SEL_BITS + 1;

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [SEL_BITS-1:0] sel_q;
  logic [SEL_BITS-1:0] sel;
  logic [SEL_BITS-1:0] rr_ptr_q;
  logic [SEL_BITS-1:0] pick_idx;
  logic                pick_found;
  logic [SCAN_W-1:0]   scan;
  logic                hs;
  logic                can_issue;
  logic                err_q;

  logic [SEL_BITS-1:0] fifo_head;
  logic [CNT_BITS-1:0] fifo_count;
  logic                fifo_full_unused;
  logic                fifo_empty;

  assign can_issue = (fifo_count < CNT_BITS'(MAX_OUTST));
  assign hs        = tcdm_req_o & tcdm_gnt_i;

  // First requester at or after rr_ptr, wrapping around the channel list.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + SCAN_W'(i);
      if (scan >= SCAN_W'(NUM_REQ)) begin
        scan = scan - SCAN_W'(NUM_REQ);
      end
      if (!pick_found && req_i[scan[SEL_BITS-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[SEL_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == HOLD) begin
        sel_q <= sel;
      end
      if (hs) begin
        rr_ptr_q <= (sel == SEL_BITS'(NUM_REQ - 1)) ? '0 : sel + SEL_BITS'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tcdm_req_o && !tcdm_gnt_i) state_d = HOLD;
      HOLD:    if (tcdm_gnt_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A HOLD already on the bus stays asserted even if the outstanding limit is reached.
  always_comb begin
    tcdm_req_o = 1'b0;
    sel        = pick_idx;
    case (state_q)
      IDLE: begin
        tcdm_req_o = pick_found && can_issue;
        sel        = pick_idx;
      end
      HOLD: begin
        tcdm_req_o = 1'b1;
        sel        = sel_q;
      end
      default: begin
        tcdm_req_o = 1'b0;
        sel        = pick_idx;
      end
    endcase
    gnt_o = '0;
    if (tcdm_req_o && tcdm_gnt_i) begin
      gnt_o[sel] = 1'b1;
    end
    tcdm_add_o   = '0;
    tcdm_we_o    = 1'b0;
    tcdm_wdata_o = '0;
    tcdm_be_o    = '0;
    if (tcdm_req_o) begin
      tcdm_add_o   = add_i[int'(sel)*ADDR_W +: ADDR_W];
      tcdm_we_o    = we_i[sel];
      tcdm_wdata_o = wdata_i[int'(sel)*DATA_W +: DATA_W];
      tcdm_be_o    = be_i[int'(sel)*BE_BITS +: BE_BITS];
    end
  end

  axi2mem_tcdm_arb_outst_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (SEL_BITS)
  ) u_outst_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (tcdm_r_valid_i),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty)
  );

  always_comb begin
    r_valid_o = '0;
    if (tcdm_r_valid_i && !fifo_empty) begin
      r_valid_o[fifo_head] = 1'b1;
    end
  end

  assign r_rdata_o = {NUM_REQ{tcdm_r_rdata_i}};

  // A response with nothing outstanding is a protocol error that sticks until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (tcdm_r_valid_i && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

`ifdef AXI2MEM_TCDM_ARB_PERF_EN
  logic [31:0] gnt_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  // Saturating counters; clear takes priority over any increment in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_cnt_q[i] <= '0;
      end
    end else if (perf_clr_i) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_cnt_q[i] <= '0;
      end
    end else begin
      if (tcdm_req_o && !tcdm_gnt_i && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs && sel == SEL_BITS'(i) && gnt_cnt_q[i] != 32'hFFFF_FFFF) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_gnt_cnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_gnt_cnt_o[i*32 +: 32] = gnt_cnt_q[i];
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
`else
  logic perf_clr_unused;

  assign perf_clr_unused  = perf_clr_i;
  assign perf_gnt_cnt_o   = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi2mem_tcdm_port_arb.sv
// Directed testbench for axi2mem_tcdm_port_arb with NUM_REQ=4, MAX_OUTST=4.
// Perf expectations follow AXI2MEM_TCDM_ARB_PERF_EN when it is defined for the build.
module tb_axi2mem_tcdm_port_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_i;
  logic [NR*AW-1:0] add_i;
  logic [NR-1:0]    we_i;
  logic [NR*DW-1:0] wdata_i;
  logic [NR*BW-1:0] be_i;
  logic [NR-1:0]    gnt_o;
  logic [NR*DW-1:0] r_rdata_o;
  logic [NR-1:0]    r_valid_o;
  logic             tcdm_req_o;
  logic [AW-1:0]    tcdm_add_o;
  logic             tcdm_we_o;
  logic [DW-1:0]    tcdm_wdata_o;
  logic [BW-1:0]    tcdm_be_o;
  logic             tcdm_gnt_i;
  logic [DW-1:0]    tcdm_r_rdata_i;
  logic             tcdm_r_valid_i;
  logic             err_o;
  logic             perf_clr_i;
  logic [NR*32-1:0] perf_gnt_cnt_o;
  logic [31:0]      perf_stall_cnt_o;

  int checks = 0;
  int passed = 0;

  axi2mem_tcdm_port_arb #(
    .NUM_REQ   (NR),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_OUTST (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .add_i            (add_i),
    .we_i             (we_i),
    .wdata_i          (wdata_i),
    .be_i             (be_i),
    .gnt_o            (gnt_o),
    .r_rdata_o        (r_rdata_o),
    .r_valid_o        (r_valid_o),
    .tcdm_req_o       (tcdm_req_o),
    .tcdm_add_o       (tcdm_add_o),
    .tcdm_we_o        (tcdm_we_o),
    .tcdm_wdata_o     (tcdm_wdata_o),
    .tcdm_be_o        (tcdm_be_o),
    .tcdm_gnt_i       (tcdm_gnt_i),
    .tcdm_r_rdata_i   (tcdm_r_rdata_i),
    .tcdm_r_valid_i   (tcdm_r_valid_i),
    .err_o            (err_o),
    .perf_clr_i       (perf_clr_i),
    .perf_gnt_cnt_o   (perf_gnt_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [AW-1:0] exp_add(input int ch);
    return 32'hA000_0000 + 32'(ch * 16);
  endfunction

  function automatic logic [NR-1:0] onehot(input int ch);
    logic [NR-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  // Inputs change #1 after a rising edge; checks sample #1 later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req_i          = '0;
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    perf_clr_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [NR-1:0] ch_we;
    ch_we = 4'b1010;
    for (int i = 0; i < NR; i++) begin
      add_i[i*AW +: AW]   = exp_add(i);
      wdata_i[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      be_i[i*BW +: BW]    = BW'(1 << i);
    end
    we_i           = ch_we;
    tcdm_r_rdata_i = 32'h5A5A_0001;
    do_reset();
    settle();
    checks++; if (gnt_o !== '0) $display("[TB] FAIL reset_gnt got=%b want=0", gnt_o); else passed++;
    checks++; if (tcdm_req_o !== 1'b0) $display("[TB] FAIL reset_req got=%b want=0", tcdm_req_o); else passed++;
    checks++; if (tcdm_add_o !== '0) $display("[TB] FAIL reset_add got=%h want=0", tcdm_add_o); else passed++;
    checks++; if (r_valid_o !== '0) $display("[TB] FAIL reset_rvalid got=%b want=0", r_valid_o); else passed++;
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err got=%b want=0", err_o); else passed++;
    checks++; if (perf_gnt_cnt_o !== '0 || perf_stall_cnt_o !== '0)
      $display("[TB] FAIL reset_perf got=%h/%h want=0", perf_gnt_cnt_o, perf_stall_cnt_o); else passed++;
  endtask

  // All channels requesting with immediate grant: grants 0,1,2,3,0 and responses in the same order.
  task automatic test_round_robin();
    int exp_ch;
    for (int k = 0; k < 5; k++) begin
      req_i          = 4'hF;
      tcdm_gnt_i     = 1'b1;
      tcdm_r_valid_i = (k > 0);
      tcdm_r_rdata_i = 32'h1111_0000 + 32'(k);
      settle();
      exp_ch = k % NR;
      checks++; if (gnt_o !== onehot(exp_ch))
        $display("[TB] FAIL rr_gnt cycle=%0d got=%b want=%b", k, gnt_o, onehot(exp_ch)); else passed++;
      checks++; if (tcdm_add_o !== exp_add(exp_ch))
        $display("[TB] FAIL rr_add cycle=%0d got=%h want=%h", k, tcdm_add_o, exp_add(exp_ch)); else passed++;
      checks++; if (tcdm_we_o !== (exp_ch % 2 == 1) || tcdm_wdata_o !== 32'hD000_0000 + 32'(exp_ch) || tcdm_be_o !== BW'(1 << exp_ch))
        $display("[TB] FAIL rr_payload cycle=%0d got=%b/%h/%b", k, tcdm_we_o, tcdm_wdata_o, tcdm_be_o); else passed++;
      if (k > 0) begin
        checks++; if (r_valid_o !== onehot((k - 1) % NR))
          $display("[TB] FAIL rr_rvalid cycle=%0d got=%b want=%b", k, r_valid_o, onehot((k - 1) % NR)); else passed++;
        checks++; if (r_rdata_o[((k - 1) % NR)*DW +: DW] !== 32'h1111_0000 + 32'(k))
          $display("[TB] FAIL rr_rdata cycle=%0d got=%h", k, r_rdata_o[((k - 1) % NR)*DW +: DW]); else passed++;
      end
      tick();
    end
    idle_inputs();
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== 4'b0001) $display("[TB] FAIL rr_last_rvalid got=%b want=0001", r_valid_o); else passed++;
    tick();
    idle_inputs();
  endtask

  // rr_ptr is 1 here; the held channel stays on the bus until granted.
  task automatic test_hold();
    for (int k = 0; k < 4; k++) begin
      req_i      = 4'b0110;
      tcdm_gnt_i = (k == 3);
      settle();
      checks++; if (tcdm_add_o !== exp_add(1) || tcdm_req_o !== 1'b1)
        $display("[TB] FAIL hold_add cycle=%0d got=%h req=%b want=%h", k, tcdm_add_o, tcdm_req_o, exp_add(1)); else passed++;
      checks++; if (gnt_o !== ((k == 3) ? 4'b0010 : 4'b0000))
        $display("[TB] FAIL hold_gnt cycle=%0d got=%b", k, gnt_o); else passed++;
      tick();
    end
    req_i      = 4'b0100;
    tcdm_gnt_i = 1'b1;
    settle();
    checks++; if (gnt_o !== 4'b0100) $display("[TB] FAIL hold_next_gnt got=%b want=0100", gnt_o); else passed++;
    tick();
    idle_inputs();
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== 4'b0010) $display("[TB] FAIL hold_rvalid0 got=%b want=0010", r_valid_o); else passed++;
    tick();
    settle();
    checks++; if (r_valid_o !== 4'b0100) $display("[TB] FAIL hold_rvalid1 got=%b want=0100", r_valid_o); else passed++;
    tick();
    idle_inputs();
  endtask

  // rr_ptr is 3 here; four grants fill the outstanding FIFO.
  task automatic test_outst_limit();
    int order [4] = '{3, 0, 1, 2};
    for (int k = 0; k < 4; k++) begin
      req_i      = 4'hF;
      tcdm_gnt_i = 1'b1;
      settle();
      checks++; if (gnt_o !== onehot(order[k]))
        $display("[TB] FAIL limit_gnt cycle=%0d got=%b want=%b", k, gnt_o, onehot(order[k])); else passed++;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (tcdm_req_o !== 1'b0 || gnt_o !== '0)
        $display("[TB] FAIL limit_block cycle=%0d req=%b gnt=%b want=0", k, tcdm_req_o, gnt_o); else passed++;
      tick();
    end
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== 4'b1000 || tcdm_req_o !== 1'b0)
      $display("[TB] FAIL limit_pop got=%b req=%b want=1000/0", r_valid_o, tcdm_req_o); else passed++;
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    checks++; if (gnt_o !== 4'b1000) $display("[TB] FAIL limit_regrant got=%b want=1000", gnt_o); else passed++;
    tick();
    settle();
    checks++; if (tcdm_req_o !== 1'b0) $display("[TB] FAIL limit_reblock got=%b want=0", tcdm_req_o); else passed++;
  endtask

  // FIFO holds 0,1,2,3 and rr_ptr is 0; exercise pop at full and push+pop one below full.
  task automatic test_push_pop();
    int drain [4] = '{2, 3, 0, 1};
    req_i          = 4'hF;
    tcdm_gnt_i     = 1'b1;
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== 4'b0001 || gnt_o !== '0)
      $display("[TB] FAIL pp_full_pop rvalid=%b gnt=%b want=0001/0000", r_valid_o, gnt_o); else passed++;
    tick();
    settle();
    checks++; if (r_valid_o !== 4'b0010 || gnt_o !== 4'b0001)
      $display("[TB] FAIL pp_same_cycle rvalid=%b gnt=%b want=0010/0001", r_valid_o, gnt_o); else passed++;
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    checks++; if (gnt_o !== 4'b0010) $display("[TB] FAIL pp_fill got=%b want=0010", gnt_o); else passed++;
    tick();
    settle();
    checks++; if (tcdm_req_o !== 1'b0) $display("[TB] FAIL pp_full_block got=%b want=0", tcdm_req_o); else passed++;
    idle_inputs();
    tcdm_r_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (r_valid_o !== onehot(drain[k]))
        $display("[TB] FAIL pp_drain idx=%0d got=%b want=%b", k, r_valid_o, onehot(drain[k])); else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_err();
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== '0 || err_o !== 1'b0)
      $display("[TB] FAIL err_empty rvalid=%b err=%b want=0/0", r_valid_o, err_o); else passed++;
    tick();
    tcdm_r_valid_i = 1'b0;
    tick();
    tick();
    settle();
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL err_sticky got=%b want=1", err_o); else passed++;
    do_reset();
    settle();
    checks++; if (err_o !== 1'b0) $display("[TB] FAIL err_cleared got=%b want=0", err_o); else passed++;
    req_i      = 4'hF;
    tcdm_gnt_i = 1'b1;
    settle();
    checks++; if (gnt_o !== 4'b0001) $display("[TB] FAIL err_after_reset_gnt got=%b want=0001", gnt_o); else passed++;
    tick();
    do_reset();
    tcdm_r_valid_i = 1'b1;
    settle();
    checks++; if (r_valid_o !== '0) $display("[TB] FAIL err_dropped got=%b want=0", r_valid_o); else passed++;
    tick();
    tcdm_r_valid_i = 1'b0;
    settle();
    checks++; if (err_o !== 1'b1) $display("[TB] FAIL err_midop got=%b want=1", err_o); else passed++;
    do_reset();
  endtask

  // Three stall cycles on ch2 followed by ten grants, then a clear that wins over a grant.
  task automatic test_perf();
    logic [31:0] exp_g2;
    logic [31:0] exp_st;
`ifdef AXI2MEM_TCDM_ARB_PERF_EN
    exp_g2 = 32'd10;
    exp_st = 32'd3;
`else
    exp_g2 = 32'd0;
    exp_st = 32'd0;
`endif
    for (int k = 0; k < 14; k++) begin
      req_i          = (k < 13) ? 4'b0100 : 4'b0000;
      tcdm_gnt_i     = (k >= 3 && k < 13);
      tcdm_r_valid_i = (k >= 4);
      settle();
      if (k >= 3 && k < 13) begin
        checks++; if (gnt_o !== 4'b0100)
          $display("[TB] FAIL perf_gnt cycle=%0d got=%b want=0100", k, gnt_o); else passed++;
      end
      tick();
    end
    idle_inputs();
    settle();
    checks++; if (perf_gnt_cnt_o[2*32 +: 32] !== exp_g2)
      $display("[TB] FAIL perf_gnt2 got=%0d want=%0d", perf_gnt_cnt_o[2*32 +: 32], exp_g2); else passed++;
    checks++; if (perf_gnt_cnt_o[0 +: 64] !== '0 || perf_gnt_cnt_o[3*32 +: 32] !== '0)
      $display("[TB] FAIL perf_gnt_other got=%h want=0", perf_gnt_cnt_o); else passed++;
    checks++; if (perf_stall_cnt_o !== exp_st)
      $display("[TB] FAIL perf_stall got=%0d want=%0d", perf_stall_cnt_o, exp_st); else passed++;
    perf_clr_i = 1'b1;
    req_i      = 4'b0100;
    tcdm_gnt_i = 1'b1;
    tick();
    idle_inputs();
    settle();
    checks++; if (perf_gnt_cnt_o !== '0 || perf_stall_cnt_o !== '0)
      $display("[TB] FAIL perf_clear got=%h/%h want=0", perf_gnt_cnt_o, perf_stall_cnt_o); else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_hold();
    test_outst_limit();
    test_push_pop();
    test_err();
    test_perf();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
